system_nios2_mul_seq: RTL and testbench
=======================================

SYSTEM_NIOS2_MUL_SEQ -- requirements
Module: system_nios2_mul_seq

Interface
REQ-001 The block SHALL have one clock and one reset: clk, reset (synchronous, active-high); no parameters.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  2  00 MUL (low word), 01 MULXSS, 10 MULXSU, 11 MULXUU (high word).
REQ-007 req_src1, req_src2  in  32 each  operands.
REQ-008 resp_valid  out  1  result present.
REQ-009 resp_ready  in  1  consumer accepts result.
REQ-010 resp_data  out  32  result word.
REQ-011 M_mul_src1, M_mul_src2  out  32 each  operands driven to the multiplier cell.
REQ-012 M_mul_cell_result  in  32  low 32 bits of cell product, valid exactly 1 cycle after operands are driven.

Function
REQ-013 States SHALL be IDLE, ISSUE, DRAIN, DONE; req_ready = 1 only in IDLE.
REQ-014 A request SHALL be accepted on a clk edge where req_valid & req_ready; operands and op are registered at that edge, IDLE -> ISSUE.
REQ-015 MUL SHALL issue one cell operation (src1, src2 full 32 bit) in the first ISSUE cycle, then go to DRAIN.
REQ-016 MULX ops SHALL issue four partial products on consecutive cycles: phase 0 aL*bL, 1 aH*bL, 2 aL*bH, 3 aH*bH, with each 16-bit half zero-extended to 32 bits; after phase 3 go to DRAIN.
REQ-017 Each cell result SHALL be captured on the edge ending the cycle after its issue and added to a 64-bit accumulator with shift 0, 16, 16, 32 for phases 0-3.
REQ-018 Signed correction SHALL be applied to the high word when the final partial product is captured: MULXSS subtracts (src1<0 ? src2 : 0) + (src2<0 ? src1 : 0); MULXSU subtracts (src1<0 ? src2 : 0); MULXUU none; all mod 2^32.
REQ-019 DRAIN SHALL last one cycle, then go to DONE with resp_data loaded (low word for MUL, corrected high word for MULX).
REQ-020 Latency: with acceptance in cycle 0, resp_valid SHALL first be high in cycle 3 for MUL and cycle 6 for MULX.
REQ-021 In DONE resp_valid = 1 and resp_data SHALL be held stable until resp_ready; on resp_valid & resp_ready go to IDLE; a new request is acceptable no earlier than the following cycle.
REQ-022 M_mul_src1/M_mul_src2 SHALL be 0 in every cycle in which no issue occurs.
REQ-023 req_valid while busy SHALL be ignored without loss of the in-flight operation; req_* changes after acceptance SHALL not affect the result.

Reset
REQ-024 On reset the block SHALL enter IDLE with req_ready = 1, resp_valid = 0, resp_data = 0, accumulator = 0, M_mul_src1 = M_mul_src2 = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation; the in-flight cell result is discarded and no response is produced.

Configuration
REQ-026 Macro SYSTEM_NIOS2_MUL_SEQ_MULX_EN defined: all four ops SHALL be supported as above.
REQ-027 Macro undefined: the four-phase path and signed correction SHALL be omitted; every op code is executed as MUL (latency 3, low word).

Verification
REQ-028 MUL 0x00012345 x 0x00000010, resp_ready = 1 -> resp_data 0x00123450, resp_valid in cycle 3, for one cycle.
REQ-029 MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> resp_data 0xFFFFFFFE in cycle 6; MULXSS same operands -> 0x00000000.
REQ-030 MULXSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULXSS 0x80000000 x 0x00000002 -> 0xFFFFFFFF.
REQ-031 MUL 7 x 6 with resp_ready = 0 for 5 cycles -> resp_data 0x0000002A held and resp_valid held; a second req_valid during the stall is not accepted (req_ready = 0).
REQ-032 Reset asserted in cycle 2 of a MULXUU -> IDLE next cycle, no resp_valid pulse; a following MUL 3 x 5 returns 0x0000000F.
REQ-033 Macro undefined: MULXUU 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 in cycle 3.

Source files
------------

// File: rtl/system_nios2_mul_seq_if.sv
// Request/response handshake bundle for the sequential Nios II multiplier.
// The master side issues requests and consumes results; the slave side is the multiplier.
interface system_nios2_mul_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/system_nios2_mul_seq.sv
// Sequential Nios II multiply unit driving an external 32x32->32 cell with one cycle of latency.
// Define SYSTEM_NIOS2_MUL_SEQ_MULX_EN to enable the four-phase MULXSS/MULXSU/MULXUU high-word path.
module system_nios2_mul_seq (
    input  logic                          clk,
    input  logic                          reset,
    system_nios2_mul_seq_if.slave         mif,
    output logic [31:0]                   M_mul_src1,
    output logic [31:0]                   M_mul_src2,
    input  logic [31:0]                   M_mul_cell_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] resp_data_q, resp_data_d;

`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;

    logic [1:0]  op_q, op_d;
    logic [1:0]  phase_q, phase_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] cap;
    logic [63:0] prod;
    logic [31:0] corr;
`else
    // Op code has no effect when only MUL is built.
    logic [1:0]  unused_op;
    assign unused_op = mif.req_op;
`endif

    assign mif.req_ready  = (state_q == IDLE);
    assign mif.resp_valid = (state_q == DONE);
    assign mif.resp_data  = resp_data_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        M_mul_src1  = 32'd0;
        M_mul_src2  = 32'd0;
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
        op_d    = op_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        cap     = {32'd0, M_mul_cell_result};
        prod    = 64'd0;
        // Two's-complement fix-up turning the unsigned high word into the signed one.
        corr    = 32'd0;
        if (op_q == OP_MULXSS)
            corr = (a_q[31] ? b_q : 32'd0) + (b_q[31] ? a_q : 32'd0);
        else if (op_q == OP_MULXSU)
            corr = a_q[31] ? b_q : 32'd0;
`endif
        case (state_q)
            IDLE: begin
                if (mif.req_valid) begin
                    a_d     = mif.req_src1;
                    b_d     = mif.req_src2;
                    state_d = ISSUE;
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
                    op_d    = mif.req_op;
                    phase_d = 2'd0;
                    acc_d   = 64'd0;
`endif
                end
            end
            ISSUE: begin
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
                if (op_q == OP_MUL) begin
                    M_mul_src1 = a_q;
                    M_mul_src2 = b_q;
                    state_d    = DRAIN;
                end else begin
                    case (phase_q)
                        2'd0: begin M_mul_src1 = {16'd0, a_q[15:0]};  M_mul_src2 = {16'd0, b_q[15:0]};  end
                        2'd1: begin M_mul_src1 = {16'd0, a_q[31:16]}; M_mul_src2 = {16'd0, b_q[15:0]};  end
                        2'd2: begin M_mul_src1 = {16'd0, a_q[15:0]};  M_mul_src2 = {16'd0, b_q[31:16]}; end
                        default: begin M_mul_src1 = {16'd0, a_q[31:16]}; M_mul_src2 = {16'd0, b_q[31:16]}; end
                    endcase
                    // The result arriving now belongs to the previous phase.
                    if (phase_q == 2'd1)
                        acc_d = acc_q + cap;
                    else if (phase_q != 2'd0)
                        acc_d = acc_q + (cap << 16);
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3)
                        state_d = DRAIN;
                end
`else
                M_mul_src1 = a_q;
                M_mul_src2 = b_q;
                state_d    = DRAIN;
`endif
            end
            DRAIN: begin
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
                if (op_q == OP_MUL) begin
                    resp_data_d = M_mul_cell_result;
                end else begin
                    prod        = acc_q + (cap << 32);
                    acc_d       = prod;
                    resp_data_d = prod[63:32] - corr;
                end
`else
                resp_data_d = M_mul_cell_result;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (mif.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            resp_data_q <= 32'd0;
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
            op_q        <= 2'd0;
            phase_q     <= 2'd0;
            acc_q       <= 64'd0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resp_data_q <= resp_data_d;
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
            op_q        <= op_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_system_nios2_mul_seq.sv
// Scoreboard bench for system_nios2_mul_seq with a behavioural one-cycle multiplier cell.
// Expected words and first-valid cycles are queued at request time and checked at response.
module tb_system_nios2_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_mul_src1, M_mul_src2;
    logic [31:0] cell_res = 32'd0;
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    bit          seen = 1'b0;
    bit          rand_rr = 1'b0;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t sb[$];

    system_nios2_mul_seq_if mif();

    system_nios2_mul_seq dut (
        .clk               (clk),
        .reset             (reset),
        .mif               (mif),
        .M_mul_src1        (M_mul_src1),
        .M_mul_src2        (M_mul_src2),
        .M_mul_cell_result (cell_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) cell_res <= M_mul_src1 * M_mul_src2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
        case (op)
            2'b01:   p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'b10:   p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
            default: p = {32'd0, a} * {32'd0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        p = {32'd0, a} * {32'd0, b};
        if (op == 2'b11) p[63:32] = 32'd0;
        return p[31:0];
`endif
    endfunction

    function automatic int lat_of(input logic [1:0] op);
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
        return (op == 2'b00) ? 3 : 6;
`else
        if (op == 2'b11) return 3;
        return 3;
`endif
    endfunction

    // Returns on the falling edge of the cycle after acceptance (cycle 1).
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit want);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!mif.req_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
        mif.req_valid = 1'b1;
        mif.req_op    = op;
        mif.req_src1  = a;
        mif.req_src2  = b;
        e.data = exp;
        e.cyc  = cyc + lat_of(op);
        if (want) sb.push_back(e);
        @(negedge clk);
        mif.req_valid = 1'b0;
        mif.req_op    = 2'($urandom);
        mif.req_src1  = $urandom;
        mif.req_src2  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (mif.req_ready || mif.resp_valid) begin
                    chk("src1_quiet", M_mul_src1, 32'd0);
                    chk("src2_quiet", M_mul_src2, 32'd0);
                end
                if (mif.resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_resp", 32'd1, 32'd0);
                    end else begin
                        if (!seen) begin
                            chk("latency", 32'(cyc), 32'(sb[0].cyc));
                            seen = 1'b1;
                        end
                        chk("resp_data", mif.resp_data, sb[0].data);
                        if (mif.resp_ready) begin
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) if (rand_rr) mif.resp_ready = ($urandom_range(0, 3) != 0);

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        mif.req_valid  = 1'b0;
        mif.req_op     = 2'b00;
        mif.req_src1   = 32'd0;
        mif.req_src2   = 32'd0;
        mif.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(mif.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(mif.resp_valid), 32'd0);
        chk("rst_resp_data",  mif.resp_data,       32'd0);
        chk("rst_src1",       M_mul_src1,          32'd0);
        chk("rst_src2",       M_mul_src2,          32'd0);
        reset = 1'b0;

        send(2'b00, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 1'b1);
        drain();
`ifdef SYSTEM_NIOS2_MUL_SEQ_MULX_EN
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        send(2'b01, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1);
        send(2'b10, 32'h1234_5678, 32'h8765_4321, model(2'b10, 32'h1234_5678, 32'h8765_4321), 1'b1);
`else
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        send(2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1);
`endif
        drain();

        // Random ops with a randomly stalling consumer.
        rand_rr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            send(op, a, b, model(op, a, b), 1'b1);
        end
        drain();
        rand_rr = 1'b0;
        @(negedge clk);
        mif.resp_ready = 1'b1;
        @(negedge clk);

        // Consumer stall: result held, busy block refuses a second request.
        mif.resp_ready = 1'b0;
        send(2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
        mif.req_valid = 1'b1;
        mif.req_op    = 2'b00;
        mif.req_src1  = 32'd9;
        mif.req_src2  = 32'd9;
        for (int i = 0; i < 7; i++) begin
            chk("busy_req_ready", 32'(mif.req_ready), 32'd0);
            @(negedge clk);
        end
        mif.req_valid  = 1'b0;
        mif.resp_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);

        // Reset during the operation: nothing comes back, then a clean MUL.
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_req_ready",  32'(mif.req_ready),  32'd1);
        chk("abort_resp_valid", 32'(mif.resp_valid), 32'd0);
        repeat (8) @(negedge clk);
        send(2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
